// File: rtl/bcd_xs3_seq.sv
// bcd_xs3_seq: multi-digit BCD to Excess-3 converter time-sharing one digit converter, LSD first
module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err,
  output logic                  busy
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          r_state, w_next;
  logic [W-1:0]    r_src, r_xs3;
  logic [DIGITS-1:0] r_err;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      w_dig, w_res;
  logic            w_bad, w_last;
  assign w_dig  = r_src[3:0];
  assign w_bad  = w_dig > 4'd9;
  assign w_res  = w_bad ? 4'd0 : w_dig + 4'd3;
  assign w_last = r_cnt == LAST;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next-state decode; input is only taken in IDLE and output only released in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? CONV : IDLE;
      CONV:    w_next = w_last ? DONE : CONV;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: load on accept, then shift one converted digit in from the top per CONV cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_src <= '0;
      r_xs3 <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_src <= in_bcd;
      r_xs3 <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      r_src        <= r_src >> 4;
      r_xs3        <= {w_res, r_xs3[W-1:4]};
      r_err[r_cnt] <= w_bad;
      r_cnt        <= w_last ? r_cnt : r_cnt + 1'b1;
    end
  assign in_ready     = r_state == IDLE;
  assign busy         = r_state != IDLE;
  assign out_valid    = r_state == DONE;
  assign out_xs3      = r_xs3;
  assign out_err_mask = r_err;
  assign out_err      = |r_err;
endmodule

// File: tb/tb_bcd_xs3_seq.sv
// tb_bcd_xs3_seq: scoreboard bench with directed and randomized words against a digit-wise model
module tb_bcd_xs3_seq;
  localparam int D = 4;
  localparam int W = 4 * D;
  typedef struct { logic [W-1:0] x; logic [D-1:0] m; } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_err, busy;
  logic [W-1:0] in_bcd = '0, out_xs3;
  logic [D-1:0] out_err_mask;
  int checks = 0, passes = 0, cyc = 0;
  bit rnd = 0, pv = 0;
  exp_t sb[$];
  int acc_q[$], rises[$];
  bcd_xs3_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_xs3(out_xs3),
    .out_err_mask(out_err_mask), .out_err(out_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    e.x = '0;
    e.m = '0;
    for (int k = 0; k < D; k++) begin
      int d;
      d = int'((w >> (4 * k)) & 'hF);
      if (d <= 9) e.x = e.x | (W'(d + 3) << (4 * k));
      else e.m[k] = 1'b1;
    end
    return e;
  endfunction
  // monitor: latency on each out_valid rise, data on each output transfer
  always @(negedge clk) begin
    if (rst) pv = 0;
    else begin
      if (out_valid && !pv) begin
        rises.push_back(cyc);
        if (acc_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), D);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", out_xs3, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_xs3", out_xs3, e.x);
          chk("out_err_mask", out_err_mask, e.m);
          chk("out_err", out_err, |e.m);
        end
      end
      pv = out_valid;
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end
  task automatic send(input logic [W-1:0] w, input exp_t e, input bit push);
    int n = 0;
    in_bcd = w;
    in_valid = 1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 0, 1);
    else if (push) begin
      sb.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t mk(input logic [W-1:0] x, input logic [D-1:0] m);
    exp_t e;
    e.x = x;
    e.m = m;
    return e;
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xs3", out_xs3, 0);
    chk("rst_err", out_err, 0);
    out_ready = 1;
    send(16'h1905, mk(16'h4C38, 4'b0000), 1);
    in_valid = 0;
    drain();
    send(16'h0000, mk(16'h3333, 4'b0000), 1);
    send(16'h9999, mk(16'hCCCC, 4'b0000), 1);
    send(16'h12A9, mk(16'h450C, 4'b0010), 1);
    in_valid = 0;
    drain();
    out_ready = 0;
    send(16'h1905, mk(16'h4C38, 4'b0000), 1);
    in_valid = 0;
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_valid_seen", out_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2 == 0);
      in_bcd = 16'h0777;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_xs3", out_xs3, 16'h4C38);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_back_idle", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    drain();
    rises.delete();
    send(16'h0123, mk(16'h3456, 4'b0000), 1);
    send(16'h4567, mk(16'h789A, 4'b0000), 1);
    in_valid = 0;
    drain();
    chk("tp_count", rises.size(), 2);
    if (rises.size() == 2) chk("tp_gap", rises[1] - rises[0], D + 2);
    send(16'h1234, mk(16'h0, 4'b0), 0);
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_xs3", out_xs3, 0);
    chk("mid_err", out_err, 0);
    @(posedge clk);
    #1 rst = 0;
    send(16'h0042, mk(16'h3375, 4'b0000), 1);
    in_valid = 0;
    drain();
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] w;
      for (int k = 0; k < D; k++)
        w[4*k +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      send(w, model(w), 1);
      if ($urandom_range(0, 2) == 0) begin in_valid = 0; @(posedge clk); #1; end
    end
    in_valid = 0;
    drain();
    rnd = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bcd_xs3_seq.md
# bcd_xs3_seq

Multi-digit BCD-to-Excess-3 conversion sequencer. It accepts a packed word of DIGITS BCD nibbles over a valid/ready handshake and time-shares one single-digit BCD→XS3 converter across all digits, one digit per clock, least-significant digit first. It presents the assembled XS3 word with per-digit invalid flags over a second valid/ready handshake. It sits between a BCD source (keypad/counter register) and any XS3 consumer (display or adder stage).

## Interface

Parameters:
- DIGITS, default 4: number of BCD digits per word. Legal range is 2–8.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: in_bcd is valid.
- in_ready, output, 1: block can accept a word.
- in_bcd, input, 4*DIGITS: BCD word; digit k occupies [4k+3:4k].
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_xs3, output, 4*DIGITS: XS3 result; digit k occupies [4k+3:4k].
- out_err_mask, output, DIGITS: bit k set means input digit k was greater than 9.
- out_err, output, 1: OR-reduction of out_err_mask.
- busy, output, 1: high in CONV and DONE.

## Operation

- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_bcd into the source shift register, clear digit counter, out_err_mask and out_xs3 to 0, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle, the shared converter processes the low nibble of the source register.
  - Valid digit d (0–9) produces d+3, truncated to 4 bits: 0→0011, 9→1100.
  - Invalid digit (10–15) produces 0000 and sets out_err_mask[counter].
  - The result nibble shifts into out_xs3 from the top ([4*DIGITS-1:4*DIGITS-4]). out_xs3 shifts right 4 bits. The source register shifts right 4 bits. The counter increments.
  - When counter==DIGITS-1 on a clock edge, that edge performs the final digit and the FSM goes to DONE. After DIGITS shifts, digit 0 lands in out_xs3[3:0].
- DONE:
  - out_valid=1. out_xs3, out_err_mask and out_err are held stable.
  - On out_ready: go to IDLE.
  - in_valid is ignored while not in IDLE.
- No input/output overlap. The next word is accepted only after returning to IDLE.
- out_err is combinational from out_err_mask.
- busy and in_ready are mutually exclusive and are decoded from state.
- out_xs3 and out_err_mask are meaningful only while out_valid=1. During CONV they show partial shift contents.
- Counter width is clog2(DIGITS). The counter never wraps past DIGITS-1.

## Timing

- Reset values: in_ready=1, out_valid=0, busy=0, out_xs3=0, out_err_mask=0, out_err=0.
- Asserting rst at any time returns the FSM to IDLE immediately and zeroes all registers, including mid-CONV and mid-DONE. An in-flight word is discarded and no out_valid is produced.
- Accept at edge t. CONV occupies edges t+1 … t+DIGITS. out_valid rises after edge t+DIGITS. Latency from accept to out_valid is DIGITS cycles.
- out_valid stays high until an edge with out_ready=1. out_valid falls and in_ready rises after that edge.
- With in_valid and out_ready held at 1, one word completes every DIGITS+2 cycles.
- out_ready asserted before DONE has no effect. out_ready=1 on entry to DONE still holds out_valid high for at least one cycle.
- If in_valid and out_ready are asserted together in DONE, only the output transfer occurs. The input is accepted no earlier than the following IDLE cycle.

## Test plan

- Reset check: assert rst for 2 cycles. Then in_ready=1, out_valid=0, busy=0, out_xs3=0, out_err=0.
- Basic conversion (DIGITS=4): in_bcd=16'h1905, out_ready=1. Then out_valid rises exactly 4 cycles after accept, out_xs3=16'h4C38, out_err_mask=4'b0000, out_err=0. Also in_bcd=16'h0000 gives 16'h3333, and 16'h9999 gives 16'hCCCC.
- Invalid digit: in_bcd=16'h12A9. Then out_xs3=16'h450C, out_err_mask=4'b0010, out_err=1.
- Backpressure: complete a conversion, hold out_ready=0 for 5 cycles, and pulse in_valid during that time. Then out_valid and out_xs3 stay stable, in_ready stays 0, and the pulsed input is never captured. After out_ready=1, the FSM returns to IDLE one cycle later.
- Throughput: stream 16'h0123 then 16'h4567 with in_valid=1 and out_ready=1. Then results are 16'h3456 and 16'h789A, exactly 6 cycles apart.
- Reset mid-operation: assert rst asynchronously 2 cycles into CONV. Then outputs go to reset values immediately with no out_valid. A following word 16'h0042 yields 16'h3375 normally.
